fifo2uart_packer: RTL and testbench
===================================

Name: fifo2uart_packer

Overview:
- Drains a sample FIFO and serialises each DATA_W-bit word into ceil(DATA_W/8) UART bytes, one byte per transmitter handshake.
- Generalised successor of the fixed 12-bit, two-byte FIFO-to-UART control.
- Configurable word width and byte order, with an enable gate, busy and overrun status, and an optional frame-header byte.
- Sits between the ADC sample FIFO (normal mode: q valid one cycle after rdreq) and the uart_tx block.

Parameters:
- DATA_W, 12: FIFO word width, 1..32.
- MSB_FIRST, 0: 0 = least-significant byte sent first; 1 = most-significant byte first.
- FRAME_LEN, 256: words per frame (used only with FIFO2UART_HDR_EN), at least 1.
- HDR_BYTE, 8'hA5: frame sync byte (used only with FIFO2UART_HDR_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous to clk, active-low.
- enable  in  1  allows starting a new word; sampled only in IDLE.
- fifo_rdreq  out  1  one-cycle read strobe to the FIFO.
- fifo_data  in  DATA_W  FIFO q; valid the cycle after fifo_rdreq.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- uart_en_send  out  1  one-cycle send strobe to uart_tx.
- uart_data  out  8  byte to transmit; held stable until uart_tx_done.
- uart_tx_done  in  1  one-cycle pulse when the transmitter has finished a byte.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: fifo_full was seen high.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - fifo_rdreq=0, uart_en_send=0, uart_data=8'h00, busy=0, overrun=0.
  - Byte index = 0, word counter = 0, shift register = 0.
  - Reset mid-word abandons the word; no further strobes are issued.
- NBYTES = ceil(DATA_W/8). The word is zero-extended to NBYTES*8 bits. Byte k is bits [8k+7:8k]. Send order is k = 0..NBYTES-1, or reversed when MSB_FIRST=1.
- FSM states: IDLE, RDREQ, LATCH, SEND, WAIT (plus HDR_SEND and HDR_WAIT with the optional feature).
  - IDLE: if enable && !fifo_empty, go to RDREQ. Otherwise stay.
  - RDREQ: fifo_rdreq=1 for exactly this cycle; go to LATCH.
  - LATCH: capture fifo_data into the shift register; byte index = 0; go to SEND.
  - SEND: drive uart_data with the selected byte; uart_en_send=1 for exactly this cycle; go to WAIT.
  - WAIT: on uart_tx_done, if byte index == NBYTES-1 go to IDLE; else increment the byte index and go to SEND. Without uart_tx_done, stay indefinitely.
- Latency: first uart_en_send is 3 cycles after the IDLE cycle that sees the start condition. The next word's fifo_rdreq is at least 1 cycle after the last uart_tx_done.
- uart_tx_done outside WAIT/HDR_WAIT is ignored.
- A single FIFO word is read per transaction. fifo_rdreq is never asserted while fifo_empty was high in the deciding cycle.
- enable deasserted mid-word: the current word (and header) completes, then the block idles.
- overrun:
  - Set in the cycle after fifo_full is seen high.
  - Cleared by overrun_clr.
  - Set wins over clear when both occur in the same cycle.
  - Informational only; the data path is unaffected.
- DATA_W <= 8: NBYTES=1 and MSB_FIRST has no effect.

Optional Feature:
- Macro FIFO2UART_HDR_EN.
- Defined:
  - In IDLE with the start condition and word counter == 0, the path is HDR_SEND (uart_data=HDR_BYTE, uart_en_send pulse) then HDR_WAIT (wait for uart_tx_done) then RDREQ.
  - The word counter increments at each word's final uart_tx_done and wraps to 0 after FRAME_LEN-1.
  - Reset clears the counter.
- Undefined: no header states and no word counter; HDR_BYTE and FRAME_LEN are unused.

Decomposition:
- Package fifo2uart_pkg holds:
  - The state enum typedef.
  - A function nbytes(DATA_W).
  - A default header constant (8'hA5).
- One sub-module is natural: byte_sel. It is a combinational mux from the padded word, byte index and MSB_FIRST to an 8-bit byte, reusable by future DAC command packers.

Test Plan:
- Defaults, FIFO holds 12'hABC, tx_done returned 10 cycles after each send:
  - Bytes 8'hBC then 8'h0B.
  - One fifo_rdreq.
  - busy falls the cycle after the second tx_done.
- DATA_W=24, MSB_FIRST=1, word 24'h123456 -> bytes 12, 34, 56 in order, each uart_en_send exactly 1 cycle wide.
- fifo_empty held high with enable=1 for 100 cycles -> no fifo_rdreq, no uart_en_send, busy=0.
- enable dropped during the first byte's WAIT with 3 words queued -> the current word finishes (2 bytes), then no further rdreq.
- fifo_full pulsed for 1 cycle, then overrun_clr and fifo_full asserted in the same cycle -> overrun stays 1; a later lone clr -> 0.
- FIFO2UART_HDR_EN with FRAME_LEN=2 and words 1, 2, 3 -> A5,01,00,02,00,A5,03,00; rst_n low mid-stream, then 5 words -> the stream restarts with A5.

Source files
------------

// File: rtl/fifo2uart_pkg.sv
// Shared types and helpers for the FIFO-to-UART packer family.
// Holds the state encoding, byte-count math and the default frame sync byte.
package fifo2uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RDREQ    = 3'd1,
    LATCH    = 3'd2,
    SEND     = 3'd3,
    WAIT     = 3'd4,
    HDR_SEND = 3'd5,
    HDR_WAIT = 3'd6
  } state_t;

  localparam logic [7:0] DEFAULT_HDR = 8'hA5;

  function automatic int nbytes(input int data_w);
    return (data_w + 7) / 8;
  endfunction

  // Counter/index width for n distinct values; never below one bit.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo2uart_packer_if.sv
// FIFO read side and UART transmit side of the packer, bundled as one interface.
// Handshake: fifo_rdreq and uart_en_send are single-cycle strobes; uart_data is held until uart_tx_done pulses for one cycle.
interface fifo2uart_packer_if #(
  parameter int DATA_W = 12
);

  logic              fifo_rdreq;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic              uart_en_send;
  logic [7:0]        uart_data;
  logic              uart_tx_done;

  modport master (
    output fifo_rdreq,
    output uart_en_send,
    output uart_data,
    input  fifo_data,
    input  fifo_empty,
    input  fifo_full,
    input  uart_tx_done
  );

  modport slave (
    input  fifo_rdreq,
    input  uart_en_send,
    input  uart_data,
    output fifo_data,
    output fifo_empty,
    output fifo_full,
    output uart_tx_done
  );

endinterface

// File: rtl/fifo2uart_packer_byte_sel.sv
// Picks one byte out of a zero-padded multi-byte word, LSB-first or MSB-first.
// Purely combinational so other packers can reuse it.
module byte_sel #(
  parameter int NBYTES    = 2,
  parameter int IDX_W     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [NBYTES*8-1:0] word,
  input  logic [IDX_W-1:0]    idx,
  output logic [7:0]          sel_byte
);

  logic [IDX_W-1:0] k;

  always_comb begin
    k        = MSB_FIRST ? (IDX_W'(NBYTES - 1) - idx) : idx;
    sel_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (k == IDX_W'(i)) sel_byte = word[i*8 +: 8];
    end
  end

endmodule

// File: rtl/fifo2uart_packer.sv
// Drains one FIFO word at a time and sends it as ceil(DATA_W/8) UART bytes.
// Define FIFO2UART_HDR_EN to prefix every FRAME_LEN words with a HDR_BYTE sync byte.
module fifo2uart_packer
  import fifo2uart_pkg::*;
#(
  parameter int         DATA_W    = 12,
  parameter bit         MSB_FIRST = 1'b0,
  parameter int         FRAME_LEN = 256,
  parameter logic [7:0] HDR_BYTE  = DEFAULT_HDR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                overrun_clr,
  fifo2uart_packer_if.master  bus,
  output logic                busy,
  output logic                overrun,
  output state_t              state_dbg
);

  localparam int NBYTES = nbytes(DATA_W);
  localparam int IDX_W  = sel_w(NBYTES);
  localparam int PAD_W  = NBYTES * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PAD_W-1:0]  shift_q;
  logic [7:0]        sel_byte;
  logic              start;

  assign start = enable && !bus.fifo_empty;

`ifdef FIFO2UART_HDR_EN
  localparam int CNT_W = sel_w(FRAME_LEN);
  logic [CNT_W-1:0] word_cnt_q;
  logic             word_done;

  assign word_done = (state_q == WAIT) && bus.uart_tx_done && (idx_q == LAST_IDX);

  // Position of the next word within the frame; zero means a header is due.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else if (word_done) begin
      word_cnt_q <= (word_cnt_q == CNT_W'(FRAME_LEN - 1)) ? '0 : word_cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef FIFO2UART_HDR_EN
          state_d = (word_cnt_q == '0) ? HDR_SEND : RDREQ;
`else
          state_d = RDREQ;
`endif
        end
      end
`ifdef FIFO2UART_HDR_EN
      HDR_SEND: state_d = HDR_WAIT;
      HDR_WAIT: if (bus.uart_tx_done) state_d = RDREQ;
`endif
      RDREQ: state_d = LATCH;
      LATCH: begin
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (bus.uart_tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == LATCH) shift_q <= PAD_W'(bus.fifo_data);
    end
  end

  // Set has priority so a full flag coinciding with a clear is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (bus.fifo_full) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  byte_sel #(
    .NBYTES    (NBYTES),
    .IDX_W     (IDX_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_byte_sel (
    .word     (shift_q),
    .idx      (idx_q),
    .sel_byte (sel_byte)
  );

  assign bus.fifo_rdreq   = (state_q == RDREQ);
  assign bus.uart_en_send = (state_q == SEND) || (state_q == HDR_SEND);
  assign bus.uart_data    = ((state_q == HDR_SEND) || (state_q == HDR_WAIT)) ? HDR_BYTE : sel_byte;
  assign busy             = (state_q != IDLE);
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_fifo2uart_packer.sv
// Bench for fifo2uart_packer: a 12-bit LSB-first instance, a 24-bit MSB-first instance,
// and with FIFO2UART_HDR_EN a FRAME_LEN=2 instance for the frame header path.
module tb_fifo2uart_packer;
  import fifo2uart_pkg::*;

`ifdef FIFO2UART_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- instance A: 12-bit, LSB first ----------------
  fifo2uart_packer_if #(.DATA_W(12)) bus_a ();
  logic   en_a = 1'b0, clr_a = 1'b0, busy_a, ovr_a;
  state_t st_a;

  fifo2uart_packer #(.DATA_W(12), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .overrun_clr(clr_a),
    .bus(bus_a.master), .busy(busy_a), .overrun(ovr_a), .state_dbg(st_a)
  );

  logic [11:0] mem_a [0:63];
  logic [7:0]  exp_a [$];
  int push_a = 0, pop_a = 0, fc_a = 0, tx_cd_a = 0, en_cyc_a = 0;
  int last_done_a = -1, min_gap_a = 1000, bad_rd_a = 0;

  assign bus_a.fifo_empty = (push_a == pop_a);

  always @(posedge clk) begin
    if (!rst_n) begin
      pop_a <= push_a;
      tx_cd_a <= 0;
      bus_a.uart_tx_done <= 1'b0;
      last_done_a <= -1;
    end else begin
      if (bus_a.fifo_rdreq) begin
        if (push_a == pop_a) bad_rd_a <= bad_rd_a + 1;
        bus_a.fifo_data <= mem_a[pop_a % 64];
        pop_a <= pop_a + 1;
        if (last_done_a >= 0 && cyc - last_done_a < min_gap_a) min_gap_a <= cyc - last_done_a;
      end
      bus_a.uart_tx_done <= (tx_cd_a == 1);
      if (bus_a.uart_tx_done) last_done_a <= cyc;
      if (bus_a.uart_en_send) begin
        tx_cd_a <= 9;
        en_cyc_a <= en_cyc_a + 1;
      end else if (tx_cd_a > 0) begin
        tx_cd_a <= tx_cd_a - 1;
      end
    end
  end

  // ---------------- instance B: 24-bit, MSB first ----------------
  fifo2uart_packer_if #(.DATA_W(24)) bus_b ();
  logic   en_b = 1'b0, clr_b = 1'b0, busy_b, ovr_b;
  state_t st_b;

  fifo2uart_packer #(.DATA_W(24), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .overrun_clr(clr_b),
    .bus(bus_b.master), .busy(busy_b), .overrun(ovr_b), .state_dbg(st_b)
  );

  logic [23:0] mem_b [0:63];
  logic [7:0]  exp_b [$];
  int push_b = 0, pop_b = 0, fc_b = 0, tx_cd_b = 0, en_cyc_b = 0;

  assign bus_b.fifo_empty = (push_b == pop_b);

  always @(posedge clk) begin
    if (!rst_n) begin
      pop_b <= push_b;
      tx_cd_b <= 0;
      bus_b.uart_tx_done <= 1'b0;
    end else begin
      if (bus_b.fifo_rdreq) begin
        bus_b.fifo_data <= mem_b[pop_b % 64];
        pop_b <= pop_b + 1;
      end
      bus_b.uart_tx_done <= (tx_cd_b == 1);
      if (bus_b.uart_en_send) begin
        tx_cd_b <= 9;
        en_cyc_b <= en_cyc_b + 1;
      end else if (tx_cd_b > 0) begin
        tx_cd_b <= tx_cd_b - 1;
      end
    end
  end

`ifdef FIFO2UART_HDR_EN
  // ---------------- instance C: 12-bit, frame of 2 words ----------------
  fifo2uart_packer_if #(.DATA_W(12)) bus_c ();
  logic   en_c = 1'b0, clr_c = 1'b0, busy_c, ovr_c;
  state_t st_c;

  fifo2uart_packer #(.DATA_W(12), .MSB_FIRST(1'b0), .FRAME_LEN(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .overrun_clr(clr_c),
    .bus(bus_c.master), .busy(busy_c), .overrun(ovr_c), .state_dbg(st_c)
  );

  logic [11:0] mem_c [0:63];
  logic [7:0]  exp_c [$];
  int push_c = 0, pop_c = 0, tx_cd_c = 0, en_cyc_c = 0;

  assign bus_c.fifo_empty = (push_c == pop_c);

  always @(posedge clk) begin
    if (!rst_n) begin
      pop_c <= push_c;
      tx_cd_c <= 0;
      bus_c.uart_tx_done <= 1'b0;
    end else begin
      if (bus_c.fifo_rdreq) begin
        bus_c.fifo_data <= mem_c[pop_c % 64];
        pop_c <= pop_c + 1;
      end
      bus_c.uart_tx_done <= (tx_cd_c == 1);
      if (bus_c.uart_en_send) begin
        tx_cd_c <= 9;
        en_cyc_c <= en_cyc_c + 1;
      end else if (tx_cd_c > 0) begin
        tx_cd_c <= tx_cd_c - 1;
      end
    end
  end
`endif

  // ---------------- driver tasks ----------------
  task automatic push_word_a(input logic [11:0] w);
    mem_a[push_a % 64] = w;
    push_a++;
    if (HDR && fc_a == 0) exp_a.push_back(8'hA5);
    exp_a.push_back(w[7:0]);
    exp_a.push_back({4'h0, w[11:8]});
    fc_a = (fc_a + 1) % 256;
  endtask

  task automatic push_word_b(input logic [23:0] w);
    mem_b[push_b % 64] = w;
    push_b++;
    if (HDR && fc_b == 0) exp_b.push_back(8'hA5);
    exp_b.push_back(w[23:16]);
    exp_b.push_back(w[15:8]);
    exp_b.push_back(w[7:0]);
    fc_b = (fc_b + 1) % 256;
  endtask

  task automatic wait_send_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_a.uart_en_send) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_send_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_b.uart_en_send) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.fifo_rdreq, bus_a.uart_en_send, busy_a, ovr_a} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes_a got=%b exp=0000", {bus_a.fifo_rdreq, bus_a.uart_en_send, busy_a, ovr_a});
    end
    checks++;
    if (bus_a.uart_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_uart_data_a got=%h exp=00", bus_a.uart_data);
    end
    checks++;
    if ({bus_b.fifo_rdreq, bus_b.uart_en_send, busy_b, ovr_b} !== 4'b0000 || bus_b.uart_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_b got=%b/%h exp=0000/00", {bus_b.fifo_rdreq, bus_b.uart_en_send, busy_b, ovr_b}, bus_b.uart_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (st_a !== IDLE || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got=%0d/%b exp=%0d/0", st_a, busy_a, IDLE);
    end
  endtask

  task automatic test_single_word();
    int p0, e0, nb, lat, n;
    bit ok;
    logic [7:0] e;
    p0 = pop_a;
    e0 = en_cyc_a;
    lat = (HDR && fc_a == 0) ? 1 : 3;
    push_word_a(12'hABC);
    nb = exp_a.size();
    en_a = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.uart_en_send && n < 50);
    checks++;
    if (n !== lat) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=%0d", n, lat);
    end
    e = exp_a.pop_front();
    checks++;
    if (bus_a.uart_data !== e) begin
      failures++;
      $display("FAIL single_byte0 got=%h exp=%h", bus_a.uart_data, e);
    end
    while (exp_a.size() > 0) begin
      wait_send_a(ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL single_timeout got=none exp=send");
        break;
      end
      e = exp_a.pop_front();
      checks++;
      if (bus_a.uart_data !== e) begin
        failures++;
        $display("FAIL single_byte got=%h exp=%h", bus_a.uart_data, e);
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.uart_tx_done && n < 50);
    checks++;
    if (busy_a !== 1'b1 || bus_a.uart_tx_done !== 1'b1) begin
      failures++;
      $display("FAIL single_busy_at_done got=%b exp=1", busy_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_after_done got=%b exp=0", busy_a);
    end
    checks++;
    if (pop_a - p0 !== 1) begin
      failures++;
      $display("FAIL single_rdreq_count got=%0d exp=1", pop_a - p0);
    end
    checks++;
    if (en_cyc_a - e0 !== nb) begin
      failures++;
      $display("FAIL single_send_cycles got=%0d exp=%0d", en_cyc_a - e0, nb);
    end
    en_a = 1'b0;
  endtask

  task automatic test_msb_first();
    int e0, nb, n;
    bit ok;
    logic [7:0] e;
    e0 = en_cyc_b;
    push_word_b(24'h123456);
    nb = exp_b.size();
    en_b = 1'b1;
    while (exp_b.size() > 0) begin
      wait_send_b(ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL msb_timeout got=none exp=send");
        break;
      end
      e = exp_b.pop_front();
      checks++;
      if (bus_b.uart_data !== e) begin
        failures++;
        $display("FAIL msb_byte got=%h exp=%h", bus_b.uart_data, e);
      end
      @(negedge clk);
      checks++;
      if (bus_b.uart_en_send !== 1'b0) begin
        failures++;
        $display("FAIL msb_send_width got=%b exp=0", bus_b.uart_en_send);
      end
    end
    en_b = 1'b0;
    n = 0;
    while (busy_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (en_cyc_b - e0 !== nb || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL msb_send_count got=%0d/%b exp=%0d/0", en_cyc_b - e0, busy_b, nb);
    end
  endtask

  task automatic test_empty_idle();
    int bad, pa, pb;
    bad = 0;
    pa = pop_a;
    pb = pop_b;
    en_a = 1'b1;
    en_b = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus_a.fifo_rdreq || bus_a.uart_en_send || busy_a ||
          bus_b.fifo_rdreq || bus_b.uart_en_send || busy_b) bad++;
    end
    en_a = 1'b0;
    en_b = 1'b0;
    checks++;
    if (bad !== 0 || pop_a !== pa || pop_b !== pb) begin
      failures++;
      $display("FAIL empty_idle got=%0d active cycles exp=0", bad);
    end
  endtask

  task automatic test_enable_drop();
    int p0, e0, n1;
    bit ok;
    logic [7:0] e;
    p0 = pop_a;
    push_word_a(12'h111);
    n1 = exp_a.size();
    push_word_a(12'h222);
    push_word_a(12'h333);
    en_a = 1'b1;
    for (int i = 0; i < n1; i++) begin
      wait_send_a(ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL drop_timeout got=none exp=send");
        break;
      end
      if (i == 0) en_a = 1'b0;
      e = exp_a.pop_front();
      checks++;
      if (bus_a.uart_data !== e) begin
        failures++;
        $display("FAIL drop_byte got=%h exp=%h", bus_a.uart_data, e);
      end
    end
    @(negedge clk);
    e0 = en_cyc_a;
    repeat (60) @(negedge clk);
    checks++;
    if (pop_a - p0 !== 1) begin
      failures++;
      $display("FAIL drop_rdreq_count got=%0d exp=1", pop_a - p0);
    end
    checks++;
    if (en_cyc_a !== e0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle got=%0d sends/busy=%b exp=0/0", en_cyc_a - e0, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    int p0, n;
    bit ok;
    logic [7:0] e;
    p0 = pop_a;
    en_a = 1'b1;
    while (exp_a.size() > 0) begin
      wait_send_a(ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL b2b_timeout got=none exp=send");
        break;
      end
      e = exp_a.pop_front();
      checks++;
      if (bus_a.uart_data !== e) begin
        failures++;
        $display("FAIL b2b_byte got=%h exp=%h", bus_a.uart_data, e);
      end
    end
    en_a = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pop_a - p0 !== 2 || bad_rd_a !== 0) begin
      failures++;
      $display("FAIL b2b_rdreq_count got=%0d/%0d exp=2/0", pop_a - p0, bad_rd_a);
    end
    checks++;
    if (min_gap_a < 1) begin
      failures++;
      $display("FAIL b2b_rdreq_gap got=%0d exp>=1", min_gap_a);
    end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    checks++;
    if (ovr_a !== 1'b0) begin
      failures++;
      $display("FAIL ovr_initial got=%b exp=0", ovr_a);
    end
    bus_a.fifo_full = 1'b1;
    @(negedge clk);
    bus_a.fifo_full = 1'b0;
    checks++;
    if (ovr_a !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set got=%b exp=1", ovr_a);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ovr_a !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky got=%b exp=1", ovr_a);
    end
    bus_a.fifo_full = 1'b1;
    clr_a = 1'b1;
    @(negedge clk);
    bus_a.fifo_full = 1'b0;
    clr_a = 1'b0;
    checks++;
    if (ovr_a !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set_wins got=%b exp=1", ovr_a);
    end
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    checks++;
    if (ovr_a !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear got=%b exp=0", ovr_a);
    end
  endtask

`ifdef FIFO2UART_HDR_EN
  task automatic test_header();
    logic [7:0] seq1 [0:7];
    logic [7:0] seq3 [0:12];
    int e0, bad, n;
    bit ok;
    logic [7:0] e;
    seq1 = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'hA5, 8'h03, 8'h00};
    seq3 = '{8'hA5, 8'h06, 8'h00, 8'h07, 8'h00, 8'hA5, 8'h08, 8'h00,
             8'h09, 8'h00, 8'hA5, 8'h0A, 8'h00};
    for (int i = 1; i <= 3; i++) begin
      mem_c[push_c % 64] = 12'(i);
      push_c++;
    end
    for (int i = 0; i < 8; i++) exp_c.push_back(seq1[i]);
    en_c = 1'b1;
    while (exp_c.size() > 0) begin
      ok = 1'b0;
      for (int j = 0; j < 200 && !ok; j++) begin
        @(negedge clk);
        ok = bus_c.uart_en_send;
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL hdr_timeout got=none exp=send");
        break;
      end
      e = exp_c.pop_front();
      checks++;
      if (bus_c.uart_data !== e) begin
        failures++;
        $display("FAIL hdr_byte got=%h exp=%h", bus_c.uart_data, e);
      end
    end
    n = 0;
    while (busy_c && n < 100) begin
      @(negedge clk);
      n++;
    end
    // Mid-frame word, abandoned by reset after its first byte.
    mem_c[push_c % 64] = 12'h044;
    push_c++;
    mem_c[push_c % 64] = 12'h055;
    push_c++;
    ok = 1'b0;
    for (int j = 0; j < 200 && !ok; j++) begin
      @(negedge clk);
      ok = bus_c.uart_en_send;
    end
    checks++;
    if (!ok || bus_c.uart_data !== 8'h44) begin
      failures++;
      $display("FAIL hdr_midframe_byte got=%h exp=44", bus_c.uart_data);
    end
    en_c = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    fc_a = 0;
    fc_b = 0;
    @(negedge clk);
    e0 = en_cyc_c;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_c.uart_en_send || bus_c.fifo_rdreq || busy_c) bad++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus_c.uart_en_send || bus_c.fifo_rdreq || busy_c) bad++;
    end
    checks++;
    if (bad !== 0 || en_cyc_c !== e0) begin
      failures++;
      $display("FAIL hdr_reset_quiet got=%0d exp=0", bad);
    end
    for (int i = 6; i <= 10; i++) begin
      mem_c[push_c % 64] = 12'(i);
      push_c++;
    end
    for (int i = 0; i < 13; i++) exp_c.push_back(seq3[i]);
    en_c = 1'b1;
    while (exp_c.size() > 0) begin
      ok = 1'b0;
      for (int j = 0; j < 200 && !ok; j++) begin
        @(negedge clk);
        ok = bus_c.uart_en_send;
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL hdr_restart_timeout got=none exp=send");
        break;
      end
      e = exp_c.pop_front();
      checks++;
      if (bus_c.uart_data !== e) begin
        failures++;
        $display("FAIL hdr_restart_byte got=%h exp=%h", bus_c.uart_data, e);
      end
    end
    en_c = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus_a.fifo_full = 1'b0;
    bus_b.fifo_full = 1'b0;
`ifdef FIFO2UART_HDR_EN
    bus_c.fifo_full = 1'b0;
`endif
    test_reset();
    test_single_word();
    test_msb_first();
    test_empty_idle();
    test_enable_drop();
    test_back_to_back();
    test_overrun();
`ifdef FIFO2UART_HDR_EN
    test_header();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
